// File: rtl/data_mem_uart_ctrl.sv
// Data memory for the memory stage. It also holds a memory-mapped UART transmit port.
//
// Ports:
//   clk          clock; all state changes on the rising edge
//   reset        asynchronous, active-low reset
//   MemWriteM    store request from the memory stage
//   MemToRegM    load request from the memory stage
//   alu_resultM  word address of the access
//   write_dataM  store data
//   stallM       combinational; holds the pipeline while a TX store cannot be accepted
//   read_dataW   registered load data
//   read_validW  one-cycle pulse qualifying read_dataW
//   tx_data      byte offered to the UART transmitter
//   tx_valid     tx_data is valid; a byte transfers when tx_valid and tx_ready are both high
//   tx_ready     the UART transmitter can accept a byte
module data_mem_uart_ctrl #(
    parameter int unsigned RAM_AW    = 8,
    parameter logic [15:0] TX_ADDR   = 16'hFF00,
    parameter logic [15:0] STAT_ADDR = 16'hFF01
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic        MemToRegM,
    input  logic [15:0] alu_resultM,
    input  logic [15:0] write_dataM,
    output logic        stallM,
    output logic [15:0] read_dataW,
    output logic        read_validW,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    typedef enum logic {StIdle, StPend} tx_state_e;

    tx_state_e   state_q, state_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic [15:0] read_data_q, read_data_d;
    logic        read_valid_q, read_valid_d;
    logic [15:0] mem_q [2**RAM_AW];

    logic              ram_sel, tx_sel, stat_sel, tx_store;
    logic [RAM_AW-1:0] ram_idx;
    logic [15:0]       rdata;

    assign ram_sel  = (alu_resultM[15:RAM_AW] == '0);
    assign ram_idx  = alu_resultM[RAM_AW-1:0];
    assign tx_sel   = (alu_resultM == TX_ADDR);
    assign stat_sel = (alu_resultM == STAT_ADDR);
    assign tx_store = MemWriteM & tx_sel;

    assign tx_valid    = (state_q == StPend);
    assign tx_data     = tx_data_q;
    assign read_dataW  = read_data_q;
    assign read_validW = read_valid_q;

    // tx_valid is cleared asynchronously by reset, so stallM is also low during reset.
    assign stallM = tx_store & tx_valid & ~tx_ready;

    // RAM has no reset. A store is visible to a load in the next cycle.
    always_ff @(posedge clk) begin
        if (MemWriteM && ram_sel) begin
            mem_q[ram_idx] <= write_dataM;
        end
    end

    always_comb begin
        rdata = 16'h0000;
        if (ram_sel) begin
            rdata = mem_q[ram_idx];
        end else if (tx_sel) begin
            rdata = {8'h00, tx_data_q};
        end else if (stat_sel) begin
            rdata = {15'h0000, tx_valid};
        end
    end

    // A store and a load in the same cycle suppress the load.
    always_comb begin
        read_valid_d = MemToRegM & ~MemWriteM;
        read_data_d  = read_valid_d ? rdata : read_data_q;
    end

    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        unique case (state_q)
            StIdle: begin
                if (tx_store) begin
                    state_d   = StPend;
                    tx_data_d = write_dataM[7:0];
                end
            end
            StPend: begin
                if (tx_store) begin
                    // The current byte leaves and the new byte replaces it on the same edge.
                    // Without tx_ready the store stalls and nothing changes.
                    if (tx_ready) begin
                        tx_data_d = write_dataM[7:0];
                    end
                end else if (tx_ready) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            tx_data_q    <= 8'h00;
            read_data_q  <= 16'h0000;
            read_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tx_data_q    <= tx_data_d;
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
        end
    end

endmodule
